// File: rtl/fault_freeze_ctrl_pkg.sv
// Shared types and constants for the fault freeze sequencer.
// Package name: fault_freeze_pkg.
package fault_freeze_pkg;

    // Fixed state encodings, also exported on state_dbg.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        RECOVER = 3'd2,
        SETTLE  = 3'd3,
        FATAL   = 3'd4
    } state_t;

    localparam int FAULT_CNT_W = 8;

    // Width of the retry counter; never narrower than one bit.
    function automatic int retry_w(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

    // Saturating increment for the accepted-fault counter.
    function automatic logic [FAULT_CNT_W-1:0] sat_inc(input logic [FAULT_CNT_W-1:0] v);
        return (v == {FAULT_CNT_W{1'b1}}) ? v : v + FAULT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fault_freeze_ctrl_if.sv
// Signal bundle between the freeze sequencer and its environment.
//
// Handshake: recover_start is a one-cycle pulse from the sequencer that
// launches a restore; recover_done is a one-cycle pulse back from the
// checkpoint-restore unit and is only acted on while the sequencer is in
// RECOVER (a pulse at any other time is dropped). fault_in is a level,
// sampled on every rising edge.
interface fault_freeze_ctrl_if #(
    parameter int RETRY_W = 2
);
    import fault_freeze_pkg::*;

    logic                   fault_in;
    logic                   recover_done;
    logic                   freeze_en;
    logic                   recover_start;
    logic                   fatal;
    logic [2:0]             state_dbg;
    logic [RETRY_W-1:0]     retry_cnt;
    logic [FAULT_CNT_W-1:0] fault_cnt;

    modport master (
        input  fault_in, recover_done,
        output freeze_en, recover_start, fatal, state_dbg, retry_cnt, fault_cnt
    );

    modport slave (
        output fault_in, recover_done,
        input  freeze_en, recover_start, fatal, state_dbg, retry_cnt, fault_cnt
    );

endinterface

// File: rtl/fault_freeze_ctrl_timer.sv
// freeze_timer: loadable down-counter that stops at zero.
// o_expired is high whenever the count has reached zero.
module freeze_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_value;

    // Load takes priority; otherwise count down until zero and hold there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (r_value != '0) begin
            r_value <= r_value - WIDTH'(1);
        end
    end

    assign o_value   = r_value;
    assign o_expired = (r_value == '0);

endmodule

// File: rtl/fault_freeze_ctrl.sv
// fault_freeze_ctrl: freeze request sequencer
// IDLE -> DRAIN -> RECOVER -> SETTLE -> IDLE, with bounded retries and a
// sticky FATAL. Optional RECOVER watchdog built when FAULT_FREEZE_TIMEOUT_EN
// is defined.
module fault_freeze_ctrl
    import fault_freeze_pkg::*;
#(
    parameter int HOLD_CYCLES    = 4,
    parameter int MAX_RETRIES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    fault_freeze_ctrl_if.master ctrl_bus
);

    localparam int RETRY_W = retry_w(MAX_RETRIES);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRIES);

    state_t                 r_state;
    logic                   r_freeze_en;
    logic                   r_recover_start;
    logic                   r_fatal;
    logic [RETRY_W-1:0]     r_retry_cnt;
    logic [FAULT_CNT_W-1:0] r_fault_cnt;

    logic              w_hold_load;
    logic [HOLD_W-1:0] w_hold_val;
    logic [HOLD_W-1:0] w_hold_value_unused;
    logic              w_hold_expired;
    logic              w_wdog_expired;
    logic              w_fail;
    logic              w_retry_ok;
    logic              w_to_drain;
    logic              w_to_settle;
    logic              w_to_recover;

    // A failed attempt is a fault during SETTLE or a watchdog expiry in
    // RECOVER that is not rescued by a same-cycle recover_done.
    assign w_retry_ok   = (r_retry_cnt < MAX_RETRY_V);
    assign w_fail       = ((r_state == SETTLE) && ctrl_bus.fault_in) ||
                          ((r_state == RECOVER) && !ctrl_bus.recover_done && w_wdog_expired);
    assign w_to_drain   = ((r_state == IDLE) && ctrl_bus.fault_in) || (w_fail && w_retry_ok);
    assign w_to_settle  = (r_state == RECOVER) && ctrl_bus.recover_done;
    assign w_to_recover = (r_state == DRAIN) && w_hold_expired;

    // DRAIN counts HOLD_CYCLES-1 down to 0 (HOLD_CYCLES cycles); SETTLE
    // loads one more so freeze_en drops HOLD_CYCLES+1 edges after recover_done.
    assign w_hold_load = w_to_drain || w_to_settle;
    assign w_hold_val  = w_to_settle ? HOLD_W'(HOLD_CYCLES) : HOLD_W'(HOLD_CYCLES - 1);

    freeze_timer #(.WIDTH(HOLD_W)) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_hold_load),
        .i_load_val (w_hold_val),
        .o_value    (w_hold_value_unused),
        .o_expired  (w_hold_expired)
    );

`ifdef FAULT_FREEZE_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] w_wdog_value_unused;

    // Watchdog is armed on RECOVER entry and expires after TIMEOUT_CYCLES cycles there.
    freeze_timer #(.WIDTH(WDOG_W)) u_wdog_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_to_recover),
        .i_load_val (WDOG_W'(TIMEOUT_CYCLES - 1)),
        .o_value    (w_wdog_value_unused),
        .o_expired  (w_wdog_expired)
    );
`else
    localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
    assign w_wdog_expired = 1'b0;
`endif

    // Main sequencer: state plus all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_freeze_en     <= 1'b0;
            r_recover_start <= 1'b0;
            r_fatal         <= 1'b0;
            r_retry_cnt     <= '0;
            r_fault_cnt     <= '0;
        end else begin
            r_recover_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ctrl_bus.fault_in) begin
                        r_state     <= DRAIN;
                        r_freeze_en <= 1'b1;
                        r_retry_cnt <= '0;
                        r_fault_cnt <= sat_inc(r_fault_cnt);
                    end
                end
                DRAIN: begin
                    if (w_to_recover) begin
                        r_state         <= RECOVER;
                        r_recover_start <= 1'b1;
                    end
                end
                RECOVER: begin
                    if (w_to_settle) begin
                        r_state <= SETTLE;
                    end else if (w_fail) begin
                        if (w_retry_ok) begin
                            r_state     <= DRAIN;
                            r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
                        end else begin
                            r_state <= FATAL;
                            r_fatal <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (w_fail) begin
                        r_fault_cnt <= sat_inc(r_fault_cnt);
                        if (w_retry_ok) begin
                            r_state     <= DRAIN;
                            r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
                        end else begin
                            r_state <= FATAL;
                            r_fatal <= 1'b1;
                        end
                    end else if (w_hold_expired) begin
                        r_state     <= IDLE;
                        r_freeze_en <= 1'b0;
                    end
                end
                FATAL: begin
                    r_state <= FATAL;
                end
                default: begin
                    r_state     <= FATAL;
                    r_freeze_en <= 1'b1;
                    r_fatal     <= 1'b1;
                end
            endcase
        end
    end

    assign ctrl_bus.freeze_en     = r_freeze_en;
    assign ctrl_bus.recover_start = r_recover_start;
    assign ctrl_bus.fatal         = r_fatal;
    assign ctrl_bus.state_dbg     = r_state;
    assign ctrl_bus.retry_cnt     = r_retry_cnt;
    assign ctrl_bus.fault_cnt     = r_fault_cnt;

endmodule

// File: tb/tb_fault_freeze_ctrl.sv
// Bench for fault_freeze_ctrl. Timeout scenario is compiled only when
// FAULT_FREEZE_TIMEOUT_EN is defined.
module tb_fault_freeze_ctrl;
    import fault_freeze_pkg::*;

    localparam int H  = 4;
    localparam int MR = 2;
    localparam int TO = 8;
    localparam int RW = retry_w(MR);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_fcnt = 0;
    logic [31:0] exp_q[$];

    fault_freeze_ctrl_if #(.RETRY_W(RW)) bus ();

    fault_freeze_ctrl #(
        .HOLD_CYCLES    (H),
        .MAX_RETRIES    (MR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ctrl_bus (bus)
    );

    // clock / cycle stamp: cyc equals the number of rising edges seen so far
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every recover_start pulse must match the next expected edge stamp
    always @(negedge clk) begin
        if (exp_q.size() > 0 && cyc > int'(exp_q[0])) begin
            checks++; errors++;
            $display("FAIL recover_start_missing want pulse at cycle %0d, none by cycle %0d", exp_q[0], cyc);
            void'(exp_q.pop_front());
        end
        if (rst_n && bus.recover_start === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL recover_start_unexpected got pulse at cycle %0d want none", cyc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (cyc !== int'(e)) begin
                    errors++;
                    $display("FAIL recover_start_time got cycle %0d want cycle %0d", cyc, e);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic apply_reset();
        tick();
        bus.fault_in = 1'b0; bus.recover_done = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_fcnt = 0;
    endtask

    // one-cycle fault from IDLE; returns the edge where DRAIN is entered
    task automatic fault_from_idle(output int n);
        bus.fault_in = 1'b1;
        tick();
        bus.fault_in = 1'b0;
        n = cyc;
        exp_fcnt++;
        exp_q.push_back(32'(n + H));
    endtask

    task automatic done_at(input int m);
        wait_cyc(m - 1);
        bus.recover_done = 1'b1;
        tick();
        bus.recover_done = 1'b0;
    endtask

    task automatic settle_fault_at(input int f);
        wait_cyc(f - 1);
        bus.fault_in = 1'b1;
        tick();
        bus.fault_in = 1'b0;
    endtask

    task automatic test_reset();
        bus.fault_in = 1'b0; bus.recover_done = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.state_dbg !== 3'(IDLE) || bus.freeze_en !== 1'b0 || bus.recover_start !== 1'b0 ||
            bus.fatal !== 1'b0 || bus.retry_cnt !== RW'(0) || bus.fault_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_values got state=%0d freeze=%0b start=%0b fatal=%0b retry=%0d fcnt=%0d want all 0",
                     bus.state_dbg, bus.freeze_en, bus.recover_start, bus.fatal, bus.retry_cnt, bus.fault_cnt);
        end
    endtask

    task automatic test_basic();
        int n, m;
        fault_from_idle(n);
        checks++;
        if (bus.state_dbg !== 3'(DRAIN) || bus.freeze_en !== 1'b1 || bus.retry_cnt !== RW'(0) ||
            bus.fault_cnt !== 8'(exp_fcnt)) begin
            errors++;
            $display("FAIL basic_fault_latency got state=%0d freeze=%0b retry=%0d fcnt=%0d want state=1 freeze=1 retry=0 fcnt=%0d",
                     bus.state_dbg, bus.freeze_en, bus.retry_cnt, bus.fault_cnt, exp_fcnt);
        end
        wait_cyc(n + H);
        checks++;
        if (bus.state_dbg !== 3'(RECOVER) || bus.freeze_en !== 1'b1) begin
            errors++;
            $display("FAIL basic_recover_entry got state=%0d freeze=%0b want state=2 freeze=1", bus.state_dbg, bus.freeze_en);
        end
        m = n + H + 3;
        done_at(m);
        checks++;
        if (bus.state_dbg !== 3'(SETTLE) || bus.freeze_en !== 1'b1) begin
            errors++;
            $display("FAIL basic_settle_entry got state=%0d freeze=%0b want state=3 freeze=1", bus.state_dbg, bus.freeze_en);
        end
        wait_cyc(m + H);
        checks++;
        if (bus.freeze_en !== 1'b1) begin
            errors++;
            $display("FAIL basic_freeze_hold got freeze=%0b want 1 at cycle done+%0d", bus.freeze_en, H);
        end
        tick();
        checks++;
        if (bus.state_dbg !== 3'(IDLE) || bus.freeze_en !== 1'b0 || bus.retry_cnt !== RW'(0) ||
            bus.fault_cnt !== 8'(exp_fcnt)) begin
            errors++;
            $display("FAIL basic_release got state=%0d freeze=%0b retry=%0d fcnt=%0d want state=0 freeze=0 retry=0 fcnt=%0d",
                     bus.state_dbg, bus.freeze_en, bus.retry_cnt, bus.fault_cnt, exp_fcnt);
        end
    endtask

    task automatic test_retries();
        int n, m1, f1, m2, f2, m3, f3;
        apply_reset();
        fault_from_idle(n);
        m1 = n + H + 1;
        done_at(m1);
        f1 = m1 + 2;
        settle_fault_at(f1);
        exp_fcnt++;
        exp_q.push_back(32'(f1 + H));
        checks++;
        if (bus.state_dbg !== 3'(DRAIN) || bus.retry_cnt !== RW'(1) || bus.fault_cnt !== 8'(exp_fcnt) || bus.freeze_en !== 1'b1) begin
            errors++;
            $display("FAIL retry_first got state=%0d retry=%0d fcnt=%0d freeze=%0b want state=1 retry=1 fcnt=%0d freeze=1",
                     bus.state_dbg, bus.retry_cnt, bus.fault_cnt, bus.freeze_en, exp_fcnt);
        end
        m2 = f1 + H + 1 + int'($urandom_range(0, 2));
        done_at(m2);
        // fault on the final SETTLE cycle: retry must beat the return to IDLE
        f2 = m2 + H + 1;
        settle_fault_at(f2);
        exp_fcnt++;
        exp_q.push_back(32'(f2 + H));
        checks++;
        if (bus.state_dbg !== 3'(DRAIN) || bus.retry_cnt !== RW'(2) || bus.fault_cnt !== 8'(exp_fcnt) || bus.freeze_en !== 1'b1) begin
            errors++;
            $display("FAIL retry_last_settle_cycle got state=%0d retry=%0d fcnt=%0d freeze=%0b want state=1 retry=2 fcnt=%0d freeze=1",
                     bus.state_dbg, bus.retry_cnt, bus.fault_cnt, bus.freeze_en, exp_fcnt);
        end
        m3 = f2 + H + 1;
        done_at(m3);
        f3 = m3 + 1;
        settle_fault_at(f3);
        exp_fcnt++;
        checks++;
        if (bus.state_dbg !== 3'(FATAL) || bus.fatal !== 1'b1 || bus.freeze_en !== 1'b1 ||
            bus.retry_cnt !== RW'(2) || bus.fault_cnt !== 8'd4) begin
            errors++;
            $display("FAIL retry_exhausted got state=%0d fatal=%0b freeze=%0b retry=%0d fcnt=%0d want state=4 fatal=1 freeze=1 retry=2 fcnt=4",
                     bus.state_dbg, bus.fatal, bus.freeze_en, bus.retry_cnt, bus.fault_cnt);
        end
    endtask

    task automatic test_fatal_sticky();
        for (int i = 0; i < 5; i++) begin
            bus.fault_in     = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.recover_done = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (bus.state_dbg !== 3'(FATAL) || bus.fatal !== 1'b1 || bus.freeze_en !== 1'b1 ||
                bus.retry_cnt !== RW'(2) || bus.fault_cnt !== 8'(exp_fcnt)) begin
                errors++;
                $display("FAIL fatal_sticky iter %0d got state=%0d fatal=%0b freeze=%0b retry=%0d fcnt=%0d want state=4 fatal=1 freeze=1 retry=2 fcnt=%0d",
                         i, bus.state_dbg, bus.fatal, bus.freeze_en, bus.retry_cnt, bus.fault_cnt, exp_fcnt);
            end
        end
        bus.fault_in = 1'b0; bus.recover_done = 1'b0;
        #2 rst_n = 1'b0;
        exp_fcnt = 0;
        #1;
        checks++;
        if (bus.state_dbg !== 3'(IDLE) || bus.freeze_en !== 1'b0 || bus.recover_start !== 1'b0 ||
            bus.fatal !== 1'b0 || bus.retry_cnt !== RW'(0) || bus.fault_cnt !== 8'd0) begin
            errors++;
            $display("FAIL fatal_reset_exit got state=%0d freeze=%0b start=%0b fatal=%0b retry=%0d fcnt=%0d want all 0",
                     bus.state_dbg, bus.freeze_en, bus.recover_start, bus.fatal, bus.retry_cnt, bus.fault_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fault_held();
        int n, m;
        bus.fault_in = 1'b1;
        tick();
        n = cyc;
        exp_fcnt++;
        exp_q.push_back(32'(n + H));
        m = n + H + int'($urandom_range(1, 4));
        wait_cyc(m - 1);
        bus.recover_done = 1'b1;
        tick();
        bus.recover_done = 1'b0;
        bus.fault_in = 1'b0;
        checks++;
        if (bus.state_dbg !== 3'(SETTLE) || bus.retry_cnt !== RW'(0) || bus.fault_cnt !== 8'(exp_fcnt)) begin
            errors++;
            $display("FAIL held_fault_settle got state=%0d retry=%0d fcnt=%0d want state=3 retry=0 fcnt=%0d",
                     bus.state_dbg, bus.retry_cnt, bus.fault_cnt, exp_fcnt);
        end
        wait_cyc(m + H + 1);
        checks++;
        if (bus.state_dbg !== 3'(IDLE) || bus.freeze_en !== 1'b0 || bus.fault_cnt !== 8'(exp_fcnt)) begin
            errors++;
            $display("FAIL held_fault_release got state=%0d freeze=%0b fcnt=%0d want state=0 freeze=0 fcnt=%0d",
                     bus.state_dbg, bus.freeze_en, bus.fault_cnt, exp_fcnt);
        end
    endtask

    task automatic test_reset_in_recover();
        int n;
        fault_from_idle(n);
        wait_cyc(n + H + 1);
        #2 rst_n = 1'b0;
        exp_fcnt = 0;
        #1;
        checks++;
        if (bus.freeze_en !== 1'b0 || bus.state_dbg !== 3'(IDLE) || bus.fault_cnt !== 8'd0 || bus.retry_cnt !== RW'(0)) begin
            errors++;
            $display("FAIL async_reset_recover got freeze=%0b state=%0d fcnt=%0d retry=%0d want freeze=0 state=0 fcnt=0 retry=0",
                     bus.freeze_en, bus.state_dbg, bus.fault_cnt, bus.retry_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
        bus.recover_done = 1'b1;
        tick();
        bus.recover_done = 1'b0;
        tick();
        checks++;
        if (bus.state_dbg !== 3'(IDLE) || bus.freeze_en !== 1'b0 || bus.fault_cnt !== 8'd0) begin
            errors++;
            $display("FAIL late_done_ignored got state=%0d freeze=%0b fcnt=%0d want state=0 freeze=0 fcnt=0",
                     bus.state_dbg, bus.freeze_en, bus.fault_cnt);
        end
    endtask

`ifdef FAULT_FREEZE_TIMEOUT_EN
    task automatic test_timeout();
        int n, r, r2;
        fault_from_idle(n);
        r = n + H;
        wait_cyc(r + TO - 1);
        checks++;
        if (bus.state_dbg !== 3'(RECOVER)) begin
            errors++;
            $display("FAIL wdog_before_expiry got state=%0d want state=2", bus.state_dbg);
        end
        tick();
        checks++;
        if (bus.state_dbg !== 3'(DRAIN) || bus.retry_cnt !== RW'(1) || bus.fault_cnt !== 8'(exp_fcnt) || bus.freeze_en !== 1'b1) begin
            errors++;
            $display("FAIL wdog_retry got state=%0d retry=%0d fcnt=%0d freeze=%0b want state=1 retry=1 fcnt=%0d freeze=1",
                     bus.state_dbg, bus.retry_cnt, bus.fault_cnt, bus.freeze_en, exp_fcnt);
        end
        exp_q.push_back(32'(r + TO + H));
        r2 = r + TO + H;
        done_at(r2 + TO);
        checks++;
        if (bus.state_dbg !== 3'(SETTLE) || bus.retry_cnt !== RW'(1)) begin
            errors++;
            $display("FAIL wdog_done_wins got state=%0d retry=%0d want state=3 retry=1", bus.state_dbg, bus.retry_cnt);
        end
        wait_cyc(r2 + TO + H + 1);
        checks++;
        if (bus.state_dbg !== 3'(IDLE) || bus.freeze_en !== 1'b0 || bus.retry_cnt !== RW'(1)) begin
            errors++;
            $display("FAIL wdog_release_retry_hold got state=%0d freeze=%0b retry=%0d want state=0 freeze=0 retry=1",
                     bus.state_dbg, bus.freeze_en, bus.retry_cnt);
        end
    endtask
`endif

    initial begin
        bus.fault_in     = 1'b0;
        bus.recover_done = 1'b0;
        test_reset();
        test_basic();
        test_retries();
        test_fatal_sticky();
        test_fault_held();
        test_reset_in_recover();
`ifdef FAULT_FREEZE_TIMEOUT_EN
        apply_reset();
        test_timeout();
`endif
        repeat (H + 2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending recover_start want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // absolute time bound
    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1, "time limit");
    end

endmodule
